mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Memory stage of the 5-stage MIPS pipeline, between the execute stage and wb_stage.
- Holds one in-flight instruction and waits for the data-SRAM-like response (data_ok/rdata) if the instruction issued a memory request.
- Aligns and extends load data, then produces ms_to_ws_bus in exactly the field layout wb_stage consumes.
- Handles pipeline flush from WB, including discarding responses of cancelled requests.

Parameters:
- ES_TO_MS_BUS_WD, 98, input bus width: cp0[19] + byte_we[4] + ld_op[3] + has_req[1] + is_load[1] + gr_we[1] + dest[5] + alu_result[32] + pc[32].
- MS_TO_WS_BUS_WD, 93, output bus width: cp0[19] + byte_we[4] + gr_we[1] + dest[5] + final_result[32] + pc[32].
- DISCARD_CNT_W, 2, width of the cancelled-response counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- es_to_ms_valid  in  1  EX holds a valid instruction
- es_to_ms_bus  in  ES_TO_MS_BUS_WD  EX payload
- ms_allowin  out  1  MS can accept this cycle
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  MS offers an instruction to WB
- ms_to_ws_bus  out  MS_TO_WS_BUS_WD  payload to WB
- data_sram_data_ok  in  1  response strobe for the oldest outstanding request
- data_sram_rdata  in  32  response data
- ws_flush  in  1  flush_and_jump from the WB CP0 bus
- ms_ex  out  1  MS holds a valid excepting or eret instruction; EX must suppress store requests
- ms_to_ds_fwd_bus  out  39  {fwd_valid, fwd_blocked, dest[5], data[32]} for ID bypass/stall

Behaviour:
- Reset: ms_valid=0, the bus register is cleared to 0, rdata_buf_valid=0, discard_cnt=0. Consequently ms_to_ws_valid=0, ms_ex=0, fwd_valid=0.
- Handshake:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - On es_to_ms_valid && ms_allowin, the bus register loads es_to_ms_bus and ms_valid<=1.
  - Otherwise, if ms_allowin, ms_valid<=0.
- ws_flush has top priority:
  - ms_valid<=0 the next cycle, regardless of ms_allowin.
  - Incoming es_to_ms_valid is ignored.
- ms_ready_go = !has_req || rdata_buf_valid || resp_now, where resp_now = data_sram_data_ok && discard_cnt==0.
- Response capture: when resp_now && ms_valid && !(ws_allowin && ms_ready_go), latch data_sram_rdata into rdata_buf and set rdata_buf_valid<=1. The flag clears when the instruction leaves MS or on flush.
- Load data source: mem_data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- Discard counter:
  - On ws_flush while ms_valid && has_req && !rdata_buf_valid && !resp_now: discard_cnt += 1.
  - Each data_sram_data_ok while discard_cnt!=0 decrements the counter and is not delivered.
  - Same-cycle increment and decrement leave the counter unchanged.
  - The counter saturates at 3; a flush that would overflow it is a protocol error.
- Load extraction, keyed by alu_result[1:0]:
  - ld_op 0 LW: word.
  - 1 LB / 2 LBU: selected byte, sign-/zero-extended.
  - 3 LH / 4 LHU: halfword at bit 16*addr[1], sign-/zero-extended.
  - Misaligned loads never issue a request (EX flags AdEL and clears has_req); alu_result passes through as BadVAddr.
- final_result = (is_load && has_req) ? extracted data : alu_result.
- Output bus order is {cp0, byte_we, gr_we, dest, final_result, pc}.
- ms_ex = ms_valid && (cp0.ex || cp0.eret).
- Forwarding:
  - fwd_valid = ms_valid && gr_we && dest!=0.
  - fwd_blocked = is_load && !ms_ready_go.
  - data = final_result.
- Reset asserted mid-request: all state clears; in-flight responses are not tracked.

Decomposition:
- Bus widths, ld_op encodings and field offsets go in mycpu.h.
- One sub-module, load_align: combinational extract/extend of (ld_op, addr[1:0], word).

Test Plan:
- LW at 0x1000 with data_ok in the same cycle, ws_allowin=1 → ms_to_ws_valid next edge, final_result=rdata, latency 1.
- LB at addr 0x...03, rdata=0x80FF_1234 → 0xFFFF_FF80; the same case as LBU → 0x0000_0080; LHU at addr 2 → 0x0000_80FF.
- data_ok arrives while ws_allowin=0 for 3 cycles with rdata=0xDEADBEEF, bus changing afterwards → 0xDEADBEEF delivered when ws_allowin rises; ms_allowin stays 0 meanwhile.
- ws_flush while a load waits → ms_valid=0, discard_cnt=1. A new LW enters; the first data_ok (0x1111) is dropped, the second (0x2222) is delivered.
- Non-memory ADDU with ws_allowin=1 → passes in 1 cycle with alu_result unchanged and the fwd bus valid with fwd_blocked=0.
- Assert resetn=0 asynchronously mid-wait → all outputs go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mem_stage_hs_pkg.sv
// Shared widths, load-op encodings and bus layouts for the MIPS memory stage.
// The cp0 field carries ex in its top bit and eret just below it.
package mem_stage_hs_pkg;

    localparam int ES_TO_MS_BUS_WD = 98;
    localparam int MS_TO_WS_BUS_WD = 93;
    localparam int DISCARD_CNT_W   = 2;
    localparam int FWD_BUS_WD      = 39;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [DISCARD_CNT_W-1:0] DISCARD_MAX = {DISCARD_CNT_W{1'b1}};

    typedef struct packed {
        logic        ex;
        logic        eret;
        logic [16:0] info;
    } cp0_t;

    typedef struct packed {
        cp0_t        cp0;
        logic [3:0]  byte_we;
        logic [2:0]  ld_op;
        logic        has_req;
        logic        is_load;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        cp0_t        cp0;
        logic [3:0]  byte_we;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Picks the addressed byte/halfword out of a loaded word and sign- or zero-extends it.
module mem_stage_hs_load_align
    import mem_stage_hs_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];

        case (ld_op)
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'd0, byte_sel};
            LD_LH:   data = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MIPS memory stage: holds one instruction, waits for its data response,
// aligns load data and drops responses that belong to flushed requests.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_flush,
    output logic                       ms_ex,
    output logic [FWD_BUS_WD-1:0]      ms_to_ds_fwd_bus
);

    es_to_ms_t                ms_bus;
    ms_to_ws_t                ms_out;
    logic                     ms_valid;
    logic                     ms_ready_go;
    logic                     ms_leave;
    logic                     resp_now;
    logic                     rdata_buf_valid;
    logic [31:0]              rdata_buf;
    logic [31:0]              mem_data;
    logic [31:0]              load_data;
    logic [31:0]              final_result;
    logic [DISCARD_CNT_W-1:0] discard_cnt;
    logic                     disc_inc;
    logic                     disc_dec;

    // A response only belongs to us once every cancelled one has drained.
    assign resp_now    = data_sram_data_ok && (discard_cnt == '0);
    assign ms_ready_go = !ms_bus.has_req || rdata_buf_valid || resp_now;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_leave    = ms_valid && ms_ready_go && ws_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
        end else if (ws_flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_bus <= '0;
        end else if (!ws_flush && es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_buf_valid <= 1'b0;
            rdata_buf       <= '0;
        end else if (ws_flush || ms_leave) begin
            rdata_buf_valid <= 1'b0;
        end else if (resp_now && ms_valid) begin
            rdata_buf_valid <= 1'b1;
            rdata_buf       <= data_sram_rdata;
        end
    end

    assign disc_inc = ws_flush && ms_valid && ms_bus.has_req && !rdata_buf_valid && !resp_now;
    assign disc_dec = data_sram_data_ok && (discard_cnt != '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            discard_cnt <= '0;
        end else if (disc_inc && !disc_dec && discard_cnt != DISCARD_MAX) begin
            discard_cnt <= discard_cnt + 1'b1;
        end else if (!disc_inc && disc_dec) begin
            discard_cnt <= discard_cnt - 1'b1;
        end
    end

    assign mem_data = rdata_buf_valid ? rdata_buf : data_sram_rdata;

    mem_stage_hs_load_align u_load_align (
        .ld_op (ms_bus.ld_op),
        .addr  (ms_bus.alu_result[1:0]),
        .word  (mem_data),
        .data  (load_data)
    );

    assign final_result = (ms_bus.is_load && ms_bus.has_req) ? load_data : ms_bus.alu_result;

    always_comb begin
        ms_out              = '0;
        ms_out.cp0          = ms_bus.cp0;
        ms_out.byte_we      = ms_bus.byte_we;
        ms_out.gr_we        = ms_bus.gr_we;
        ms_out.dest         = ms_bus.dest;
        ms_out.final_result = final_result;
        ms_out.pc           = ms_bus.pc;
    end

    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_to_ws_bus   = ms_out;
    assign ms_ex          = ms_valid && (ms_bus.cp0.ex || ms_bus.cp0.eret);

    assign ms_to_ds_fwd_bus = {ms_valid && ms_bus.gr_we && (ms_bus.dest != 5'd0),
                               ms_bus.is_load && !ms_ready_go,
                               ms_bus.dest,
                               final_result};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized and directed bench for mem_stage_hs against a transaction-level model
// that tracks outstanding requests as a queue of live/cancelled entries.
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [97:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [92:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_flush;
    logic        ms_ex;
    logic [38:0] ms_to_ds_fwd_bus;

    always #5 clk = ~clk;

    mem_stage_hs dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_flush          (ws_flush),
        .ms_ex             (ms_ex),
        .ms_to_ds_fwd_bus  (ms_to_ds_fwd_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state: one instruction slot plus the queue of outstanding requests
    bit          m_valid;
    logic [97:0] m_bus;
    bit          m_have;
    logic [31:0] m_buf;
    bit          q[$];

    logic [18:0] f_cp0;
    logic [3:0]  f_bwe;
    logic [2:0]  f_op;
    logic        f_req, f_ld, f_gwe;
    logic [4:0]  f_dest;
    logic [31:0] f_alu, f_pc;
    bit          e_deliver, e_ready, e_allowin, e_vout;
    logic [31:0] e_fin;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_extract(logic [2:0] op, logic [1:0] a, logic [31:0] w);
        logic [31:0]        sb, sh;
        logic signed [7:0]  b8;
        logic signed [15:0] h16;
        logic signed [31:0] r;
        sb  = w >> (8 * a);
        sh  = w >> (16 * a[1]);
        b8  = sb[7:0];
        h16 = sh[15:0];
        case (op)
            3'd1: begin r = b8;  return r; end
            3'd2: return {24'd0, sb[7:0]};
            3'd3: begin r = h16; return r; end
            3'd4: return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [97:0] mk(logic [2:0] op, bit req, bit ld, bit gwe,
                                       logic [4:0] dest, logic [31:0] alu, logic [31:0] pc);
        return {19'd0, 4'd0, op, req, ld, gwe, dest, alu, pc};
    endfunction

    function automatic bit bus_has_req(logic [97:0] b);
        logic [18:0] c; logic [3:0] w; logic [2:0] o; logic r, l, g; logic [4:0] d; logic [31:0] a, p;
        {c, w, o, r, l, g, d, a, p} = b;
        return r;
    endfunction

    task automatic compute_exp();
        {f_cp0, f_bwe, f_op, f_req, f_ld, f_gwe, f_dest, f_alu, f_pc} = m_bus;
        e_deliver = 1'b0;
        if (data_sram_data_ok && q.size() > 0) e_deliver = !q[0];
        e_ready   = !f_req || m_have || e_deliver;
        e_fin     = (f_ld && f_req) ? ref_extract(f_op, f_alu[1:0], m_have ? m_buf : data_sram_rdata) : f_alu;
        e_allowin = !m_valid || (e_ready && ws_allowin);
        e_vout    = m_valid && e_ready;
    endtask

    task automatic model_check();
        compute_exp();
        check("ms_allowin", ms_allowin, e_allowin);
        check("ms_to_ws_valid", ms_to_ws_valid, e_vout);
        if (e_vout)
            check("ms_to_ws_bus", ms_to_ws_bus, {f_cp0, f_bwe, f_gwe, f_dest, e_fin, f_pc});
        check("ms_ex", ms_ex, m_valid && (f_cp0[18] || f_cp0[17]));
        if (m_valid)
            check("fwd_bus", ms_to_ds_fwd_bus, {f_gwe && (f_dest != 5'd0), f_ld && !e_ready, f_dest, e_fin});
        else
            check("fwd_valid", ms_to_ds_fwd_bus[38], 1'b0);
    endtask

    task automatic model_update();
        compute_exp();
        if (data_sram_data_ok && q.size() > 0) void'(q.pop_front());
        if (ws_flush) begin
            if (m_valid && f_req && !m_have && !e_deliver)
                foreach (q[i]) q[i] = 1'b1;
            m_valid = 1'b0;
            m_have  = 1'b0;
        end else if (e_allowin) begin
            m_have  = 1'b0;
            m_valid = es_to_ms_valid;
            if (es_to_ms_valid) begin
                m_bus = es_to_ms_bus;
                if (bus_has_req(es_to_ms_bus)) q.push_back(1'b0);
            end
        end else if (e_deliver) begin
            m_have = 1'b1;
            m_buf  = data_sram_rdata;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_bus   = '0;
        m_have  = 1'b0;
        m_buf   = '0;
        q.delete();
    endtask

    task automatic drive(input bit ev, input logic [97:0] eb, input bit wa,
                         input bit dok, input logic [31:0] rd, input bit fl);
        @(negedge clk);
        es_to_ms_valid    = ev;
        es_to_ms_bus      = eb;
        ws_allowin        = wa;
        data_sram_data_ok = dok;
        data_sram_rdata   = rd;
        ws_flush          = fl;
        #1;
        model_check();
    endtask

    task automatic commit();
        @(posedge clk);
        model_update();
    endtask

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ws_flush          = 1'b0;
    endtask

    function automatic logic [97:0] rand_bus();
        logic [18:0] c; logic [3:0] w; logic [2:0] o; logic r, l, g; logic [4:0] d; logic [31:0] a, p;
        int kind;
        c = 19'($urandom);
        c[18] = ($urandom_range(0, 7) == 0);
        c[17] = ($urandom_range(0, 7) == 0);
        d = 5'($urandom);
        g = 1'($urandom);
        a = $urandom;
        p = $urandom;
        w = 4'd0;
        o = 3'd0;
        kind = $urandom_range(0, 3);
        case (kind)
            0: begin
                o = 3'($urandom_range(0, 4));
                if (o == 3'd0) a[1:0] = 2'b00;
                if (o == 3'd3 || o == 3'd4) a[0] = 1'b0;
                r = 1'b1; l = 1'b1;
            end
            1: begin r = 1'b1; l = 1'b0; g = 1'b0; w = 4'($urandom_range(1, 15)); end
            2: begin r = 1'b0; l = 1'b0; end
            default: begin r = 1'b0; l = 1'b1; a[1:0] = 2'b01; end
        endcase
        return {c, w, o, r, l, g, d, a, p};
    endfunction

    logic [2:0]  t2_op[3]  = '{3'd1, 3'd2, 3'd4};
    logic [31:0] t2_adr[3] = '{32'h0000_1003, 32'h0000_1003, 32'h0000_1002};
    logic [31:0] t2_exp[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};

    initial begin
        logic [97:0] eb;
        idle_inputs();
        model_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ms_to_ws_valid", ms_to_ws_valid, 1'b0);
        check("rst_ms_to_ws_bus", ms_to_ws_bus, 93'd0);
        check("rst_ms_ex", ms_ex, 1'b0);
        check("rst_fwd_bus", ms_to_ds_fwd_bus, 39'd0);
        check("rst_ms_allowin", ms_allowin, 1'b1);
        @(negedge clk);
        resetn = 1'b1;

        // LW with same-cycle response
        drive(1, mk(3'd0, 1, 1, 1, 5'd2, 32'h0000_1000, 32'hBFC0_0000), 1, 0, 32'h0, 0);
        check("lw_allowin_idle", ms_allowin, 1'b1);
        commit();
        drive(0, '0, 1, 1, 32'h1234_5678, 0);
        check("lw_lat1_valid", ms_to_ws_valid, 1'b1);
        check("lw_lat1_data", ms_to_ws_bus[63:32], 32'h1234_5678);
        commit();
        drive(0, '0, 1, 0, 32'h0, 0);
        check("lw_gone", ms_to_ws_valid, 1'b0);
        commit();

        // byte / halfword extraction
        for (int i = 0; i < 3; i++) begin
            drive(1, mk(t2_op[i], 1, 1, 1, 5'd3, t2_adr[i], 32'h100 + 32'(i)), 1, 0, 32'h0, 0);
            commit();
            drive(0, '0, 1, 1, 32'h80FF_1234, 0);
            check("ld_extract", ms_to_ws_bus[63:32], t2_exp[i]);
            commit();
        end

        // response captured while WB stalls
        drive(1, mk(3'd0, 1, 1, 1, 5'd4, 32'h0000_2000, 32'h200), 1, 0, 32'h0, 0);
        commit();
        drive(0, $urandom, 0, 1, 32'hDEAD_BEEF, 0);
        check("stall_allowin", ms_allowin, 1'b0);
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(0, {$urandom, $urandom, $urandom}, 0, 0, $urandom, 0);
            check("stall_allowin_hold", ms_allowin, 1'b0);
            check("stall_data_hold", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
            commit();
        end
        drive(0, '0, 1, 0, 32'h5555_5555, 0);
        check("stall_release_valid", ms_to_ws_valid, 1'b1);
        check("stall_release_data", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
        commit();

        // flush while waiting, stale response dropped
        drive(1, mk(3'd0, 1, 1, 1, 5'd6, 32'h0000_3000, 32'h300), 1, 0, 32'h0, 0);
        commit();
        drive(0, '0, 1, 0, 32'h0, 1);
        commit();
        drive(1, mk(3'd0, 1, 1, 1, 5'd7, 32'h0000_3004, 32'h304), 1, 0, 32'h0, 0);
        check("flush_valid_cleared", ms_to_ws_valid, 1'b0);
        check("flush_discard_cnt", dut.discard_cnt, 2'd1);
        commit();
        drive(0, '0, 1, 1, 32'h0000_1111, 0);
        check("stale_dropped", ms_to_ws_valid, 1'b0);
        commit();
        drive(0, '0, 1, 1, 32'h0000_2222, 0);
        check("fresh_valid", ms_to_ws_valid, 1'b1);
        check("fresh_data", ms_to_ws_bus[63:32], 32'h0000_2222);
        commit();
        drive(0, '0, 1, 0, 32'h0, 0);
        check("discard_drained", dut.discard_cnt, 2'd0);
        commit();

        // ADDU passes straight through
        drive(1, mk(3'd0, 0, 0, 1, 5'd5, 32'hCAFE_0001, 32'h400), 1, 0, 32'h0, 0);
        commit();
        drive(0, '0, 1, 0, 32'h0, 0);
        check("addu_valid", ms_to_ws_valid, 1'b1);
        check("addu_result", ms_to_ws_bus[63:32], 32'hCAFE_0001);
        check("addu_fwd", ms_to_ds_fwd_bus, {1'b1, 1'b0, 5'd5, 32'hCAFE_0001});
        commit();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int  nc;
            bit  dok, fl;
            nc = 0;
            foreach (q[j]) if (q[j]) nc++;
            dok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 11) == 0) && (nc < 3);
            drive($urandom_range(0, 3) != 0, rand_bus(), $urandom_range(0, 3) != 0, dok, $urandom, fl);
            commit();
        end
        drive(0, '0, 1, 0, 32'h0, 1);
        commit();
        while (q.size() > 0) begin
            drive(0, '0, 1, 1, $urandom, 0);
            commit();
        end

        // asynchronous reset while a load waits
        eb = mk(3'd0, 1, 1, 1, 5'd9, 32'h0000_5000, 32'h500);
        eb[97] = 1'b1;
        drive(1, eb, 1, 0, 32'h0, 0);
        commit();
        drive(0, '0, 1, 0, 32'h0, 0);
        check("pre_rst_ms_ex", ms_ex, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", ms_to_ws_valid, 1'b0);
        check("async_rst_bus", ms_to_ws_bus, 93'd0);
        check("async_rst_ms_ex", ms_ex, 1'b0);
        check("async_rst_fwd", ms_to_ds_fwd_bus, 39'd0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        drive(1, mk(3'd0, 0, 0, 1, 5'd1, 32'h0000_0042, 32'h600), 1, 0, 32'h0, 0);
        commit();
        drive(0, '0, 1, 0, 32'h0, 0);
        check("post_rst_result", ms_to_ws_bus[63:32], 32'h0000_0042);
        commit();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
